ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Multi-cycle RV32M/RV64M multiply/divide execute unit, parametrised in XLEN and bits retired per cycle.
- Sits beside the single-cycle EX ALU. Decode steers M-extension ops (opcode 0110011, fun7 = 0000001) here.
- Valid/ready request and response handshakes. Flush input for mispredict/exception kill.
- Iterative shift-add multiply, restoring divide, with RISC-V-mandated divide-by-zero and overflow results.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- STEP_BITS, 1, bits processed per CALC cycle; must divide XLEN (1, 2, 4).
- REG_IDX_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- req_fun3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_rs1_i  in  XLEN  operand 1 (dividend / multiplicand)
- req_rs2_i  in  XLEN  operand 2 (divisor / multiplier)
- req_rd_idx_i  in  REG_IDX_WIDTH  destination register
- flush_i  in  1  kill the in-flight operation
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  consumer takes result
- resp_rd_idx_o  out  REG_IDX_WIDTH  destination of result
- resp_rd_wdata_o  out  XLEN  result
- busy_o  out  1  state != IDLE (hazard stall to ID)

Behaviour:
- Reset: one clock clk; reset rst_n is asynchronous, active-low.
  - state = IDLE; resp_valid_o = 0; resp_rd_idx_o = 0; resp_rd_wdata_o = 0; busy_o = 0.
  - Counter and accumulators are cleared.
  - Reset asserted mid-operation: outputs clear immediately; no response is ever produced for that operation.
- FSM states: IDLE, CALC, DONE.
  - req_ready_o = (state == IDLE) & ~flush_i.
  - IDLE -> CALC on accept (req_valid_i & req_ready_o). Operands, fun3 and rd are registered on that edge.
  - IDLE -> DONE instead of CALC for special cases (divide-by-zero, signed overflow): 1-cycle latency.
  - CALC runs N = XLEN/STEP_BITS cycles, counted by a down-counter. CALC -> DONE after the last step.
  - DONE holds resp_valid_o = 1 with data and rd stable until resp_ready_i. DONE -> IDLE on resp_valid_o & resp_ready_i.
  - No accept occurs in the same cycle as a response retire: one bubble between back-to-back ops.
- Latency: accept at edge T → resp_valid_o high from cycle T+N+1 for normal ops; from T+1 for special cases.
- Multiply:
  - Operands become magnitudes per signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned magnitudes.
  - Shift-add into a 2*XLEN accumulator, STEP_BITS multiplier bits per cycle.
  - Product is negated on the last cycle if the sign differs.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide:
  - Restoring, STEP_BITS quotient bits per cycle, on magnitudes.
  - Quotient sign = sign(rs1) ^ sign(rs2); remainder sign = sign(rs1). Correction is applied when registering the result.
- Special cases:
  - Divisor == 0: DIV/DIVU = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM only): DIV = most-negative; REM = 0.
- Flush: flush_i in any state → IDLE at the next edge; resp_valid_o deasserts at that edge; no response.
  - flush_i in the same cycle as req_valid_i: the request is not accepted.
  - flush_i in DONE with resp_ready_i high: the flush wins; the consumer must also ignore it.
- All arithmetic is modulo 2^XLEN. Counter width is clog2(N)+1.

Decomposition:
- Shared defines header:
  - MDU fun3 codes (MDU_MUL … MDU_REMU).
  - FSM state encodings (MDU_IDLE, MDU_CALC, MDU_DONE).
  - M-extension fun7 constant 7'b0000001.
- Existing XLEN/REG_IDX_WIDTH defines are reused as parameter defaults.
- One sub-module: mdu_div_step.
  - Combinational single restoring-division step: remainder/quotient in, conditional subtract, shifted out.
  - Instantiated STEP_BITS times in a chain. The multiply step stays inline.

Test Plan (XLEN=32, STEP_BITS=1, N=32):
- MUL rs1=7, rs2=0xFFFFFFFD accepted at T → resp_valid_o at T+33, data 0xFFFFFFEB, rd echoed; busy_o high T+1..T+33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2, each at T+33.
- Special cases, resp_valid_o at T+1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0.
- Flush:
  - flush_i on the 10th CALC cycle → resp_valid_o never rises; req_ready_o = 1 the following cycle.
  - Next DIVU 9/3 returns 3.
  - flush_i with req_valid_i same cycle → not accepted.
- Backpressure and reset:
  - resp_ready_i low 5 cycles in DONE → data/rd stable, req_ready_o = 0.
  - rst_n low mid-CALC → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared constants for the M-extension multiply/divide unit: fun3 codes,
// FSM state encoding and default widths.
package ex_mdu_pkg;

  localparam int MDU_XLEN_DEF          = 32;
  localparam int MDU_REG_IDX_WIDTH_DEF = 5;

  // fun7 value that decode uses to steer OP-class instructions to this unit
  localparam logic [6:0] MDU_FUN7 = 7'b0000001;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, emit a quotient bit.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so shifted fits XLEN+1 bits and diff's MSB is the borrow
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    next_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    next_quo = {quo[XLEN-2:0], ~diff[XLEN]};
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring
// divide, STEP_BITS bits per CALC cycle, valid/ready request and response.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN          = MDU_XLEN_DEF,
  parameter int STEP_BITS     = 1,
  parameter int REG_IDX_WIDTH = MDU_REG_IDX_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_fun3_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  input  logic [REG_IDX_WIDTH-1:0] req_rd_idx_i,
  input  logic                     flush_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [REG_IDX_WIDTH-1:0] resp_rd_idx_o,
  output logic [XLEN-1:0]          resp_rd_wdata_o,
  output logic                     busy_o
);

  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: a request transfers on a rising edge with req_valid_i & req_ready_o;
  // a response retires on a rising edge with resp_valid_o & resp_ready_i.
  mdu_state_e               state, state_next;
  logic [CW-1:0]            cnt;
  logic [2:0]               op;
  logic                     neg_q, neg_r;
  logic [XLEN-1:0]          opnd;
  logic [2*XLEN-1:0]        acc;
  logic [XLEN-1:0]          result;
  logic [REG_IDX_WIDTH-1:0] rd;

  logic            accept, is_mul, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, div_ovf, special, last;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign req_ready_o     = (state == MDU_IDLE) & ~flush_i;
  assign accept          = req_valid_i & req_ready_o;
  assign resp_valid_o    = (state == MDU_DONE);
  assign busy_o          = (state != MDU_IDLE);
  assign resp_rd_idx_o   = rd;
  assign resp_rd_wdata_o = result;
  assign last            = (cnt == CW'(1));

  assign is_mul = ~req_fun3_i[2];
  assign sgn_a  = (req_fun3_i == MDU_MULH) | (req_fun3_i == MDU_MULHSU) |
                  (req_fun3_i == MDU_DIV)  | (req_fun3_i == MDU_REM);
  assign sgn_b  = (req_fun3_i == MDU_MULH) | (req_fun3_i == MDU_DIV) | (req_fun3_i == MDU_REM);
  assign neg_a  = sgn_a & req_rs1_i[XLEN-1];
  assign neg_b  = sgn_b & req_rs2_i[XLEN-1];
  assign mag_a  = neg_a ? -req_rs1_i : req_rs1_i;
  assign mag_b  = neg_b ? -req_rs2_i : req_rs2_i;

  assign div_zero = ~is_mul & (req_rs2_i == '0);
  assign div_ovf  = ((req_fun3_i == MDU_DIV) | (req_fun3_i == MDU_REM)) &
                    (req_rs1_i == MOST_NEG) & (req_rs2_i == '1);
  assign special  = div_zero | div_ovf;
  // fun3[1] separates REM/REMU from DIV/DIVU
  assign special_res = div_zero ? (req_fun3_i[1] ? req_rs1_i : '1)
                                : (req_fun3_i[1] ? '0 : MOST_NEG);

  // acc = {partial product, remaining multiplier bits}, shifted right per step
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     sum;
  always_comb begin
    mul_acc = acc;
    sum     = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      sum     = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, opnd} : '0);
      mul_acc = {sum, mul_acc[XLEN-1:1]};
    end
  end

  // acc = {partial remainder, dividend bits becoming quotient bits}
  logic [XLEN-1:0] rem_c [STEP_BITS+1];
  logic [XLEN-1:0] quo_c [STEP_BITS+1];
  assign rem_c[0] = acc[2*XLEN-1:XLEN];
  assign quo_c[0] = acc[XLEN-1:0];
  for (genvar g = 0; g < STEP_BITS; g++) begin : g_div
    mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_c[g]),
      .quo      (quo_c[g]),
      .divisor  (opnd),
      .next_rem (rem_c[g+1]),
      .next_quo (quo_c[g+1])
    );
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;
  always_comb begin
    prod    = neg_q ? -mul_acc : mul_acc;
    quo_fix = neg_q ? -quo_c[STEP_BITS] : quo_c[STEP_BITS];
    rem_fix = neg_r ? -rem_c[STEP_BITS] : rem_c[STEP_BITS];
    final_res = '0;
    unique case (op)
      MDU_MUL:                        final_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              final_res = quo_fix;
      MDU_REM, MDU_REMU:              final_res = rem_fix;
      default:                        final_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      MDU_IDLE: if (accept) state_next = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (last) state_next = MDU_DONE;
      MDU_DONE: if (resp_ready_i) state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
    if (flush_i) state_next = MDU_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
      rd     <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        MDU_IDLE: if (accept) begin
          op    <= req_fun3_i;
          rd    <= req_rd_idx_i;
          cnt   <= CW'(N);
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
          opnd  <= is_mul ? mag_a : mag_b;
          acc   <= {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
          if (special) result <= special_res;
        end
        MDU_CALC: begin
          acc <= (op[2]) ? {rem_c[STEP_BITS], quo_c[STEP_BITS]} : mul_acc;
          cnt <= cnt - 1'b1;
          if (last) result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=32, STEP_BITS=1): directed vector table,
// randomized ops against a plain-arithmetic model, flush/backpressure/reset cases.
module tb_ex_mdu;

  localparam int XLEN = 32;
  localparam int NCYC = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [2:0]      req_fun3_i = '0;
  logic [XLEN-1:0] req_rs1_i = '0;
  logic [XLEN-1:0] req_rs2_i = '0;
  logic [4:0]      req_rd_idx_i = '0;
  logic            flush_i = 1'b0;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b1;
  logic [4:0]      resp_rd_idx_o;
  logic [XLEN-1:0] resp_rd_wdata_o;
  logic            busy_o;

  ex_mdu #(.XLEN(XLEN), .STEP_BITS(1), .REG_IDX_WIDTH(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_fun3_i      (req_fun3_i),
    .req_rs1_i       (req_rs1_i),
    .req_rs2_i       (req_rs2_i),
    .req_rd_idx_i    (req_rd_idx_i),
    .flush_i         (flush_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_rd_idx_o   (resp_rd_idx_o),
    .resp_rd_wdata_o (resp_rd_wdata_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    up = '0;
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_fun3_i   = f;
    req_rs1_i    = a;
    req_rs2_i    = b;
    req_rd_idx_i = rd;
    #1 check("req_ready_idle", req_ready_o, 1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  // Counts rising edges after the accept edge until resp_valid_o; -1 on timeout
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid_o) begin
      if (lat >= 200) begin
        lat = -1;
        break;
      end
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat;
    logic [31:0] exp;
    exp_q.push_back(model(f, a, b));
    send(f, a, b, rd);
    check({name, "_busy"}, busy_o, 1);
    wait_resp(lat);
    check({name, "_lat"}, lat, is_special(f, a, b) ? 0 : NCYC);
    exp = exp_q.pop_front();
    check({name, "_data"}, resp_rd_wdata_o, exp);
    check({name, "_rd"}, resp_rd_idx_o, rd);
    @(posedge clk);
    #1 check({name, "_retire"}, resp_valid_o, 0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners[5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int lat;
    bit seen;
    logic [31:0] held_data;
    logic [4:0]  held_rd;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    // reset state
    #1;
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd", resp_rd_idx_o, 0);
    check("rst_wdata", resp_rd_wdata_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_req_ready", req_ready_o, 1);

    // directed table: constants cross-checked against the model, then run
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_model", i), model(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1));
    end

    // randomized ops
    for (int i = 0; i < 150; i++)
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)));

    // flush on the 10th CALC cycle
    send(3'd5, 32'd1000, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", busy_o, 0);
    check("flush_resp_valid", resp_valid_o, 0);
    flush_i = 1'b0;
    #1 check("flush_req_ready", req_ready_o, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= resp_valid_o;
    end
    check("flush_no_resp", seen, 0);
    run_op("after_flush", 3'd5, 32'd9, 32'd3, 5'd4);

    // flush together with a request: not accepted
    @(negedge clk);
    req_valid_i = 1'b1; req_fun3_i = 3'd0; req_rs1_i = 32'd3; req_rs2_i = 32'd4; flush_i = 1'b1;
    #1 check("flush_req_ready_low", req_ready_o, 0);
    @(posedge clk);
    #1 check("flush_req_not_taken", busy_o, 0);
    req_valid_i = 1'b0; flush_i = 1'b0;

    // flush in DONE while resp_ready_i is high
    send(3'd4, 32'd5, 32'd0, 5'd6);
    check("done_flush_pre", resp_valid_o, 1);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk);
    #1 check("done_flush_valid", resp_valid_o, 0);
    flush_i = 1'b0;

    // backpressure: hold the response for 5 cycles
    resp_ready_i = 1'b0;
    send(3'd5, 32'd100, 32'd7, 5'd9);
    wait_resp(lat);
    check("bp_lat", lat, NCYC);
    check("bp_data", resp_rd_wdata_o, 32'd14);
    held_data = resp_rd_wdata_o;
    held_rd   = resp_rd_idx_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid%0d", i), resp_valid_o, 1);
      check($sformatf("bp_data%0d", i), resp_rd_wdata_o, held_data);
      check($sformatf("bp_rd%0d", i), resp_rd_idx_o, held_rd);
      check($sformatf("bp_ready%0d", i), req_ready_o, 0);
    end
    @(negedge clk) resp_ready_i = 1'b1;
    @(posedge clk);
    #1 check("bp_retire", resp_valid_o, 0);

    // asynchronous reset mid-CALC
    send(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", resp_valid_o, 0);
    check("arst_rd", resp_rd_idx_o, 0);
    check("arst_wdata", resp_rd_wdata_o, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= resp_valid_o;
    end
    check("arst_no_resp", seen, 0);
    run_op("after_reset", 3'd0, 32'd6, 32'd7, 5'd8);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
